threshold_coincidence_trigger: RTL and testbench

THRESHOLD_COINCIDENCE_TRIGGER -- requirements
Module: threshold_coincidence_trigger

---
 rtl/threshold_coincidence_trigger_pkg.sv | 19 +
 rtl/threshold_coincidence_trigger_popcount_prio.sv | 28 ++
 rtl/threshold_coincidence_trigger.sv | 190 +++++++++++++++++++
 tb/tb_threshold_coincidence_trigger.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_coincidence_trigger_pkg.sv
// rtl/threshold_coincidence_trigger_pkg.sv - shared types and widths for the coincidence trigger
package threshold_coincidence_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } trig_state_e;

  // Width of the trigger and expired-window event counters
  localparam int CNT16_W = 16;

  // Counter width for a cycle count of n; counters hold at most n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/threshold_coincidence_trigger_popcount_prio.sv
// rtl/threshold_coincidence_trigger_popcount_prio.sv - popcount and lowest set index of a channel vector
module trig_popcount_prio #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = $clog2(NUM_CH + 1),
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_vec,
  output logic [CNT_W-1:0]  o_count,
  output logic [IDX_W-1:0]  o_low_idx,
  output logic              o_any
);

  // Count set bits and find the lowest set index; scanning downward leaves the lowest one last
  always_comb begin
    o_count   = '0;
    o_low_idx = '0;
    o_any     = |i_vec;
    for (int i = 0; i < NUM_CH; i++) begin
      o_count = o_count + CNT_W'(i_vec[i]);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_low_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/threshold_coincidence_trigger.sv
// rtl/threshold_coincidence_trigger.sv - M-of-N coincidence trigger with window, fire pulse and holdoff
module threshold_coincidence_trigger
  import threshold_coincidence_trigger_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int TS_W        = 16,
  parameter int WIN_CYC     = 4,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic                     rx_std_clkout,
  input  logic                     rst_n,
  input  logic                     cfg_enable,
  input  logic [5:0]               cfg_min_hits,
  input  logic [NUM_CH-1:0]        cfg_ch_mask,
  input  logic [NUM_CH-1:0]        ch_decision,
  input  logic [NUM_CH*TS_W-1:0]   ch_time_stamp,
  output logic [TS_W-1:0]          triggering_time_stamp,
  output logic [NUM_CH-1:0]        trig_hit_mask,
  output logic                     threshold_decision_to_DRAM_ctrl,
  output logic                     trig_busy,
  output logic [CNT16_W-1:0]       trig_count,
  output logic [CNT16_W-1:0]       expired_count
);

  localparam int WIN_W = cnt_width(WIN_CYC);
  localparam int HO_W  = cnt_width(HOLDOFF_CYC);
  localparam int PC_W  = $clog2(NUM_CH + 1);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYC - 1);
  localparam bit               WIN_ONE  = (WIN_CYC == 1);

  trig_state_e         r_state;
  trig_state_e         w_state_next;
  logic [NUM_CH-1:0]   r_acc;
  logic [WIN_W-1:0]    r_win_cnt;
  logic [HO_W-1:0]     r_ho_cnt;
  logic [TS_W-1:0]     r_ts_lat;
  logic [TS_W-1:0]     r_trig_ts;
  logic [NUM_CH-1:0]   r_trig_mask;
  logic                r_pulse;
  logic [CNT16_W-1:0]  r_trig_count;
  logic [CNT16_W-1:0]  r_exp_count;

  logic [NUM_CH-1:0]   w_hits;
  logic [NUM_CH-1:0]   w_acc_next;
  logic [PC_W-1:0]     w_pop;
  logic [IDX_W-1:0]    w_low_idx;
  logic                w_any;
  logic [5:0]          w_eff_min;
  logic                w_fire_ok;
  logic [TS_W-1:0]     w_ts_low;
  logic                w_open;
  logic                w_fire;
  logic                w_expire;

  // The accumulator is always clear in IDLE, so one counter serves both the opening and the collecting case
  assign w_hits     = ch_decision & cfg_ch_mask;
  assign w_acc_next = ((r_state == ST_IDLE) ? '0 : r_acc) | w_hits;
  assign w_eff_min  = (cfg_min_hits == 6'd0) ? 6'd1 : cfg_min_hits;
  assign w_fire_ok  = (8'(w_pop) >= 8'(w_eff_min));
  assign w_ts_low   = ch_time_stamp[int'(w_low_idx)*TS_W +: TS_W];

  trig_popcount_prio #(
    .NUM_CH (NUM_CH),
    .CNT_W  (PC_W),
    .IDX_W  (IDX_W)
  ) u_popcount_prio (
    .i_vec     (w_acc_next),
    .o_count   (w_pop),
    .o_low_idx (w_low_idx),
    .o_any     (w_any)
  );

  // State register
  always_ff @(posedge rx_std_clkout or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and event strobes; fire takes priority over the window closing in the same cycle
  always_comb begin
    w_state_next = r_state;
    w_open       = 1'b0;
    w_fire       = 1'b0;
    w_expire     = 1'b0;
    if (!cfg_enable) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            w_open = 1'b1;
            if (w_fire_ok) begin
              w_fire       = 1'b1;
              w_state_next = ST_FIRE;
            end else if (WIN_ONE) begin
              w_expire     = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_state_next = ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (w_fire_ok) begin
            w_fire       = 1'b1;
            w_state_next = ST_FIRE;
          end else if (r_win_cnt == WIN_LAST) begin
            w_expire     = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        ST_FIRE: begin
          w_state_next = ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (r_ho_cnt == HO_LAST) begin
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Window accumulation, latched trigger results, holdoff timing and event counters
  always_ff @(posedge rx_std_clkout or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_win_cnt    <= '0;
      r_ho_cnt     <= '0;
      r_ts_lat     <= '0;
      r_trig_ts    <= '0;
      r_trig_mask  <= '0;
      r_pulse      <= 1'b0;
      r_trig_count <= '0;
      r_exp_count  <= '0;
    end else begin
      r_pulse <= w_fire;

      if (w_state_next == ST_IDLE) begin
        r_acc <= '0;
      end else if (w_open || r_state == ST_COLLECT) begin
        r_acc <= w_acc_next;
      end

      if (w_state_next == ST_IDLE) begin
        r_win_cnt <= '0;
      end else if (w_open) begin
        r_win_cnt <= WIN_W'(1);
      end else if (r_state == ST_COLLECT && w_state_next == ST_COLLECT) begin
        r_win_cnt <= r_win_cnt + 1'b1;
      end

      if (w_open) begin
        r_ts_lat <= w_ts_low;
      end

      if (w_fire) begin
        r_trig_ts    <= w_open ? w_ts_low : r_ts_lat;
        r_trig_mask  <= w_acc_next;
        r_trig_count <= r_trig_count + 1'b1;
      end

      if (w_expire) begin
        r_exp_count <= r_exp_count + 1'b1;
      end

      if (r_state == ST_HOLDOFF && w_state_next == ST_HOLDOFF) begin
        r_ho_cnt <= r_ho_cnt + 1'b1;
      end else begin
        r_ho_cnt <= '0;
      end
    end
  end

  assign triggering_time_stamp           = r_trig_ts;
  assign trig_hit_mask                   = r_trig_mask;
  assign threshold_decision_to_DRAM_ctrl = r_pulse;
  assign trig_busy                       = (r_state != ST_IDLE);
  assign trig_count                      = r_trig_count;
  assign expired_count                   = r_exp_count;

endmodule

// File: tb/tb_threshold_coincidence_trigger.sv
// tb/tb_threshold_coincidence_trigger.sv - self-checking bench for threshold_coincidence_trigger
module tb_threshold_coincidence_trigger;

  localparam int NCH  = 8;
  localparam int TSW  = 16;
  localparam int WIN  = 4;
  localparam int HOLD = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_enable;
  logic [5:0]       cfg_min_hits;
  logic [NCH-1:0]   cfg_ch_mask;
  logic [NCH-1:0]   ch_decision;
  logic [NCH*TSW-1:0] ch_time_stamp;
  logic [TSW-1:0]   triggering_time_stamp;
  logic [NCH-1:0]   trig_hit_mask;
  logic             pulse;
  logic             trig_busy;
  logic [15:0]      trig_count;
  logic [15:0]      expired_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  threshold_coincidence_trigger #(
    .NUM_CH(NCH), .TS_W(TSW), .WIN_CYC(WIN), .HOLDOFF_CYC(HOLD)
  ) dut (
    .rx_std_clkout                   (clk),
    .rst_n                           (rst_n),
    .cfg_enable                      (cfg_enable),
    .cfg_min_hits                    (cfg_min_hits),
    .cfg_ch_mask                     (cfg_ch_mask),
    .ch_decision                     (ch_decision),
    .ch_time_stamp                   (ch_time_stamp),
    .triggering_time_stamp           (triggering_time_stamp),
    .trig_hit_mask                   (trig_hit_mask),
    .threshold_decision_to_DRAM_ctrl (pulse),
    .trig_busy                       (trig_busy),
    .trig_count                      (trig_count),
    .expired_count                   (expired_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a window is an age counter and an OR-set of channels; after a trigger
  // the block is unavailable for the pulse cycle plus HOLD dead cycles.
  bit          m_win  = 1'b0;
  int          m_age  = 0;
  int          m_dead = 0;
  logic [7:0]  m_acc  = '0;
  logic [15:0] m_ts_first = '0;
  logic [7:0]  m_h;
  int          m_need;
  int          m_idx;
  logic        e_pulse = 1'b0;
  logic        e_busy  = 1'b0;
  logic [15:0] e_ts    = '0;
  logic [7:0]  e_mask  = '0;
  logic [15:0] e_tc    = '0;
  logic [15:0] e_ec    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_win = 1'b0; m_age = 0; m_dead = 0; m_acc = '0; m_ts_first = '0;
      e_pulse = 1'b0; e_busy = 1'b0; e_ts = '0; e_mask = '0; e_tc = '0; e_ec = '0;
    end else begin
      m_h    = ch_decision & cfg_ch_mask;
      m_need = (cfg_min_hits == 6'd0) ? 1 : int'(cfg_min_hits);
      e_pulse = 1'b0;
      if (!cfg_enable) begin
        m_win = 1'b0; m_acc = '0; m_dead = 0;
      end else if (m_dead > 0) begin
        m_dead--;
      end else if (m_win || m_h != 8'h00) begin
        if (!m_win) begin
          m_win = 1'b1; m_age = 0; m_acc = '0;
          m_idx = 0;
          for (int i = NCH - 1; i >= 0; i--) if (m_h[i]) m_idx = i;
          m_ts_first = ch_time_stamp[m_idx*TSW +: TSW];
        end
        m_acc = m_acc | m_h;
        m_age++;
        if ($countones(m_acc) >= m_need) begin
          e_pulse = 1'b1; e_ts = m_ts_first; e_mask = m_acc; e_tc = e_tc + 16'd1;
          m_win = 1'b0; m_acc = '0; m_dead = 1 + HOLD;
        end else if (m_age == WIN) begin
          m_win = 1'b0; m_acc = '0; e_ec = e_ec + 16'd1;
        end
      end
      e_busy = m_win || (m_dead > 0);
    end
  end

  // Every-cycle comparison of all outputs against the model, mid-cycle
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_pulse", 32'(pulse), 32'(e_pulse));
      chk("cyc_busy", 32'(trig_busy), 32'(e_busy));
      chk("cyc_ts", 32'(triggering_time_stamp), 32'(e_ts));
      chk("cyc_mask", 32'(trig_hit_mask), 32'(e_mask));
      chk("cyc_trig_count", 32'(trig_count), 32'(e_tc));
      chk("cyc_expired_count", 32'(expired_count), 32'(e_ec));
    end
  end

  task automatic tick(input logic [7:0] d);
    ch_decision = d;
    @(posedge clk);
    #1;
    ch_decision = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(8'h00);
  endtask

  task automatic set_ts(input int ch, input logic [15:0] v);
    ch_time_stamp[ch*TSW +: TSW] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_enable = 1'b0; cfg_min_hits = 6'd2; cfg_ch_mask = 8'hFF; ch_decision = 8'h00;
    for (int i = 0; i < NCH; i++) ch_time_stamp[i*TSW +: TSW] = 16'h1000 + 16'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pulse", 32'(pulse), 32'h0);
    chk("rst_busy", 32'(trig_busy), 32'h0);
    chk("rst_tc", 32'(trig_count), 32'h0);
    chk("rst_ts", 32'(triggering_time_stamp), 32'h0);
    rst_n = 1'b1; cfg_enable = 1'b1; chk_on = 1'b1;
    idle(2);

    // two hits two cycles apart, pulse on the cycle after the second
    set_ts(2, 16'h0100);
    tick(8'h04); tick(8'h00);
    chk("t1_no_pulse_yet", 32'(pulse), 32'h0);
    tick(8'h20);
    chk("t1_pulse", 32'(pulse), 32'h1);
    chk("t1_ts", 32'(triggering_time_stamp), 32'h0100);
    chk("t1_mask", 32'(trig_hit_mask), 32'h24);
    chk("t1_tc", 32'(trig_count), 32'h1);
    chk("t1_model_ts", 32'(e_ts), 32'h0100);

    // holdoff: hits 5 cycles after the pulse ignored, 17 cycles after accepted
    set_ts(0, 16'h0A00);
    idle(5); tick(8'h03); idle(11);
    chk("t2_holdoff_tc", 32'(trig_count), 32'h1);
    chk("t2_holdoff_over", 32'(trig_busy), 32'h0);
    tick(8'h03);
    chk("t2_pulse", 32'(pulse), 32'h1);
    chk("t2_tc", 32'(trig_count), 32'h2);
    chk("t2_mask", 32'(trig_hit_mask), 32'h03);
    idle(20);

    // simultaneous hits, lowest channel supplies the time stamp
    set_ts(1, 16'h0010); set_ts(6, 16'h0020);
    tick(8'h42);
    chk("t3_pulse", 32'(pulse), 32'h1);
    chk("t3_ts", 32'(triggering_time_stamp), 32'h0010);
    chk("t3_mask", 32'(trig_hit_mask), 32'h42);
    idle(20);

    // single hit expires after the window
    tick(8'h08);
    chk("t4_busy", 32'(trig_busy), 32'h1);
    idle(3);
    chk("t4_idle", 32'(trig_busy), 32'h0);
    chk("t4_ec", 32'(expired_count), 32'h1);
    chk("t4_model_ec", 32'(e_ec), 32'h1);
    idle(2);

    // masked channel 0: window opens on ch4 only
    cfg_ch_mask = 8'hFE; set_ts(4, 16'h0444);
    tick(8'h11); idle(3);
    chk("t5_ec", 32'(expired_count), 32'h2);
    chk("t5_tc", 32'(trig_count), 32'h3);
    tick(8'h11); tick(8'h40);
    chk("t5b_pulse", 32'(pulse), 32'h1);
    chk("t5b_ts", 32'(triggering_time_stamp), 32'h0444);
    chk("t5b_mask", 32'(trig_hit_mask), 32'h50);
    idle(20);
    cfg_ch_mask = 8'hFF;

    // fire on the last window cycle beats expiry
    tick(8'h01); idle(2); tick(8'h02);
    chk("t6_pulse", 32'(pulse), 32'h1);
    chk("t6_tc", 32'(trig_count), 32'h5);
    chk("t6_ec", 32'(expired_count), 32'h2);
    idle(20);

    // min_hits 0 behaves as 1
    cfg_min_hits = 6'd0;
    tick(8'h80);
    chk("t7_pulse", 32'(pulse), 32'h1);
    chk("t7_mask", 32'(trig_hit_mask), 32'h80);
    idle(20);

    // min_hits above channel count never fires
    cfg_min_hits = 6'd9;
    tick(8'hFF); idle(3);
    chk("t8_tc", 32'(trig_count), 32'h6);
    chk("t8_ec", 32'(expired_count), 32'h3);
    chk("t8_mask_held", 32'(trig_hit_mask), 32'h80);
    cfg_min_hits = 6'd2;

    // enable low aborts a window without counting it
    tick(8'h01);
    cfg_enable = 1'b0; tick(8'h00);
    chk("t9_abort_busy", 32'(trig_busy), 32'h0);
    chk("t9_abort_ec", 32'(expired_count), 32'h3);
    cfg_enable = 1'b1;
    tick(8'h02); idle(3);
    chk("t9_ec", 32'(expired_count), 32'h4);

    // enable low during the pulse: pulse completes, holdoff is skipped
    tick(8'h03);
    chk("t9b_pulse", 32'(pulse), 32'h1);
    cfg_enable = 1'b0; tick(8'h00);
    chk("t9b_after", 32'(trig_busy), 32'h0);
    cfg_enable = 1'b1; tick(8'h03);
    chk("t9b_refire", 32'(pulse), 32'h1);
    chk("t9b_tc", 32'(trig_count), 32'h8);
    idle(20);

    // reset in the middle of a window
    tick(8'h08);
    chk("t10_busy", 32'(trig_busy), 32'h1);
    rst_n = 1'b0; #1;
    chk("t10_rst_busy", 32'(trig_busy), 32'h0);
    chk("t10_rst_tc", 32'(trig_count), 32'h0);
    chk("t10_rst_mask", 32'(trig_hit_mask), 32'h0);
    chk("t10_rst_pulse", 32'(pulse), 32'h0);
    idle(2);
    rst_n = 1'b1;
    tick(8'h00);
    chk("t10_idle", 32'(trig_busy), 32'h0);
    tick(8'h03);
    chk("t10_tc", 32'(trig_count), 32'h1);
    idle(20);

    // lowering min_hits mid-window fires on the existing accumulation
    cfg_min_hits = 6'd3;
    tick(8'h01); tick(8'h02);
    cfg_min_hits = 6'd2;
    tick(8'h00);
    chk("t11_pulse", 32'(pulse), 32'h1);
    chk("t11_mask", 32'(trig_hit_mask), 32'h03);
    chk("t11_ts", 32'(triggering_time_stamp), 32'h0A00);
    idle(4);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
